// File: rtl/demux1to4_stream_pkg.sv
// Shared lane constants and FSM state encoding for the 1-to-4 stream demux.
package demux1to4_stream_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned LANE_W    = 2;

    typedef logic [LANE_W-1:0] lane_t;

    localparam lane_t LANE_A = 2'd0;
    localparam lane_t LANE_B = 2'd1;
    localparam lane_t LANE_C = 2'd2;
    localparam lane_t LANE_D = 2'd3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/demux1to4_stream_lane_buf.sv
// One-entry output register for a single lane; supports drain and refill in the same cycle.
module lane_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         lin,
    output logic [W-1:0] dout,
    output logic         lout,
    output logic         valid,
    input  logic         ready
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;
    logic         last_q, last_d;

    // Next-state: a load always wins (full stays set), otherwise a drain empties the entry.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        last_d = last_q;
        if (load) begin
            full_d = 1'b1;
            data_d = din;
            last_d = lin;
        end else if (full_q && ready) begin
            full_d = 1'b0;
        end
    end

    // Entry registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            last_q <= last_d;
        end
    end

    assign dout  = data_q;
    assign lout  = last_q;
    assign valid = full_q;

endmodule

// File: rtl/demux1to4_stream.sv
// Packet-aware 1-to-4 stream demultiplexer: the lane is chosen at packet start and held until the last beat.
module demux1to4_stream
    import demux1to4_stream_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             s0,
    input  logic             s1,
    output logic [4*W-1:0]   out_data,
    output logic [3:0]       out_valid,
    output logic [3:0]       out_last,
    input  logic [3:0]       out_ready,
    output logic [1:0]       cur_lane,
    output logic             locked
);

    state_e                 state_q, state_d;
    lane_t                  lane_q, lane_d;
    lane_t                  sel_c;
    lane_t                  route_c;
    logic                   accept_c;
    logic [NUM_LANES-1:0]   load_c;
    logic [NUM_LANES-1:0]   full_c;

    assign sel_c = {s1, s0};

    // Routing, input handshake and lane load strobes.
    always_comb begin
        route_c  = (state_q == ST_LOCKED) ? lane_q : sel_c;
        in_ready = ~rst & (~full_c[route_c] | out_ready[route_c]);
        accept_c = in_valid & in_ready;
        load_c   = NUM_LANES'(accept_c) << route_c;
    end

    // Packet-lock FSM next state; the lane is captured only on a non-final first beat.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c && !in_last) begin
                    state_d = ST_LOCKED;
                    lane_d  = sel_c;
                end
            end
            ST_LOCKED: begin
                if (accept_c && in_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and captured lane registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lane_q  <= LANE_A;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
        end
    end

    // One output register per lane.
    for (genvar gi = 0; gi < int'(NUM_LANES); gi++) begin : g_lane
        lane_buf #(
            .W(W)
        ) u_lane_buf (
            .clk   (clk),
            .rst   (rst),
            .load  (load_c[gi]),
            .din   (in_data),
            .lin   (in_last),
            .dout  (out_data[gi*W +: W]),
            .lout  (out_last[gi]),
            .valid (out_valid[gi]),
            .ready (out_ready[gi])
        );
    end

    assign full_c   = out_valid;
    assign cur_lane = route_c;
    assign locked   = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_demux1to4_stream.sv
// Scoreboard bench for demux1to4_stream: directed scenarios followed by random traffic.
module tb_demux1to4_stream;

    localparam int unsigned W = 8;

    logic           clk;
    logic           rst;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_last;
    logic           in_ready;
    logic           s0;
    logic           s1;
    logic [4*W-1:0] out_data;
    logic [3:0]     out_valid;
    logic [3:0]     out_last;
    logic [3:0]     out_ready;
    logic [1:0]     cur_lane;
    logic           locked;

    demux1to4_stream #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .s0        (s0),
        .s1        (s1),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .cur_lane  (cur_lane),
        .locked    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected contents per lane: {last, data}, oldest first.
    logic [W:0] sb [4][$];
    bit         m_locked = 1'b0;
    logic [1:0] m_lane   = 2'd0;
    bit         mon_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; predicts handshake from the model and records accepted beats.
    task automatic cycle(input bit r, input bit v, input logic [1:0] s, input logic [W-1:0] d,
                         input bit l, input logic [3:0] ordy);
        logic [1:0] el;
        bit         eready;
        bit         acc;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        {s1, s0}  = s;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
        #3;
        el     = m_locked ? m_lane : s;
        eready = !r && (sb[el].size() == 0 || ordy[el]);
        if (mon_en) begin
            chk("in_ready", 64'(in_ready), 64'(eready));
            chk("cur_lane", 64'(cur_lane), 64'(el));
            chk("locked",   64'(locked),   64'(m_locked));
        end
        acc = v && eready;
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 4; i++) sb[i].delete();
            m_locked = 1'b0;
            m_lane   = 2'd0;
        end else if (acc) begin
            sb[el].push_back({l, d});
            if (!m_locked && !l) begin
                m_locked = 1'b1;
                m_lane   = s;
            end else if (m_locked && l) begin
                m_locked = 1'b0;
            end
        end
    endtask

    // Monitor: compares every presented lane against the head of its queue, pops on transfer.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (mon_en) begin
                for (int i = 0; i < 4; i++) begin
                    chk($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'(sb[i].size() != 0));
                    if (out_valid[i] && sb[i].size() != 0) begin
                        chk($sformatf("lane%0d_beat", i),
                            64'({out_last[i], out_data[i*W +: W]}), 64'(sb[i][0]));
                        if (out_ready[i] && !rst) void'(sb[i].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        s0 = 1'b0; s1 = 1'b0; out_ready = 4'hF;

        // Reset state
        cycle(1, 0, 2'd0, 8'h00, 0, 4'hF);
        cycle(1, 0, 2'd0, 8'h00, 0, 4'hF);
        mon_en = 1'b1;
        chk("rst_out_valid", 64'(out_valid), 64'(4'b0000));
        chk("rst_locked",    64'(locked),    64'(1'b0));
        chk("rst_out_data",  64'(out_data),  64'(0));
        cycle(0, 0, 2'd1, 8'h00, 0, 4'hF);

        // Single beat to lane c
        cycle(0, 1, 2'd2, 8'hA5, 1, 4'hF);
        chk("single_valid", 64'(out_valid),      64'(4'b0100));
        chk("single_data",  64'(out_data[23:16]), 64'(8'hA5));
        chk("single_last",  64'(out_last[2]),    64'(1'b1));
        chk("single_lock",  64'(locked),         64'(1'b0));
        cycle(0, 0, 2'd2, 8'h00, 0, 4'hF);

        // Lock: select changes mid-packet must not move the packet
        cycle(0, 1, 2'd1, 8'h11, 0, 4'hF);
        chk("lock_b1", 64'(locked), 64'(1'b1));
        cycle(0, 1, 2'd3, 8'h22, 0, 4'hF);
        chk("lock_b2_valid", 64'(out_valid), 64'(4'b0010));
        chk("lock_b2_data",  64'(out_data[15:8]), 64'(8'h22));
        cycle(0, 1, 2'd3, 8'h33, 1, 4'hF);
        chk("lock_b3_valid", 64'(out_valid), 64'(4'b0010));
        chk("lock_b3_data",  64'(out_data[15:8]), 64'(8'h33));
        chk("lock_b3_lock",  64'(locked), 64'(1'b0));
        cycle(0, 0, 2'd3, 8'h00, 0, 4'hF);

        // Backpressure on lane a, then same-cycle drain and refill
        cycle(0, 1, 2'd0, 8'h01, 1, 4'b1110);
        cycle(0, 1, 2'd0, 8'h02, 1, 4'b1110);
        chk("bp_hold_data", 64'(out_data[7:0]), 64'(8'h01));
        cycle(0, 1, 2'd0, 8'h02, 1, 4'b1111);
        chk("bp_refill_data",  64'(out_data[7:0]), 64'(8'h02));
        chk("bp_refill_valid", 64'(out_valid[0]),  64'(1'b1));

        // Independence: lane a stalled and full, lane d still flows
        cycle(0, 1, 2'd3, 8'h5A, 1, 4'b1110);
        chk("indep_valid", 64'(out_valid), 64'(4'b1001));
        chk("indep_data",  64'(out_data[31:24]), 64'(8'h5A));
        cycle(0, 0, 2'd0, 8'h00, 0, 4'hF);

        // Reset in the middle of a packet to lane c
        cycle(0, 1, 2'd2, 8'hC1, 0, 4'hF);
        cycle(0, 1, 2'd2, 8'hC2, 0, 4'hF);
        cycle(1, 1, 2'd2, 8'hC3, 0, 4'hF);
        chk("mid_rst_valid", 64'(out_valid), 64'(4'b0000));
        chk("mid_rst_lock",  64'(locked),    64'(1'b0));
        cycle(0, 1, 2'd0, 8'h77, 1, 4'hF);
        chk("post_rst_valid", 64'(out_valid),     64'(4'b0001));
        chk("post_rst_data",  64'(out_data[7:0]), 64'(8'h77));

        // Random traffic
        for (int n = 0; n < 10000; n++) begin
            cycle(($urandom_range(0, 499) == 0),
                  ($urandom_range(0, 9) < 7),
                  2'($urandom_range(0, 3)),
                  W'($urandom),
                  ($urandom_range(0, 9) < 3),
                  4'($urandom));
        end

        // Drain everything left
        for (int n = 0; n < 4; n++) cycle(0, 0, 2'd0, 8'h00, 0, 4'hF);
        for (int i = 0; i < 4; i++) chk($sformatf("drained%0d", i), 64'(sb[i].size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
